// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch path: datapath width,
// fetch sequencer state encoding and the fetch watchdog limit.
package cpu_pkg;

  localparam int XLEN   = 16;
  localparam int WDOG_W = 8;

  localparam logic [WDOG_W-1:0] FETCH_TIMEOUT = 8'd255;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  // States in which a memory read is outstanding and an ack is awaited.
  function automatic logic is_mem_wait(input fetch_state_t s);
    return (s == ST_FETCH) || (s == ST_FLUSH);
  endfunction

endpackage

// File: rtl/fetch_wdog.sv
// Fetch watchdog: counts consecutive unacknowledged wait cycles and flags
// expiry when the count reaches FETCH_TIMEOUT. Built only with FETCH_SEQ_TIMEOUT_EN.
module fetch_wdog
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  output logic expired
);

  logic [WDOG_W-1:0] cnt_reg;

  // Any cycle that is not an idle wait (ack, redirect, state exit) restarts the count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (count_en) begin
      cnt_reg <= cnt_reg + 1'b1;
    end else begin
      cnt_reg <= '0;
    end
  end

  assign expired = count_en && (cnt_reg == FETCH_TIMEOUT);

endmodule

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: FETCH/HOLD/FLUSH/HALT control of PC and memory
// reads. Optional fetch timeout watchdog enabled by FETCH_SEQ_TIMEOUT_EN.
module fetch_seq
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic            pc_ld,
  output logic            pc_inc,
  output logic [XLEN-1:0] pc_target,
  output logic            mem_rd,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_data,
  output logic [XLEN-1:0] ir,
  output logic            ir_valid,
  input  logic            ir_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            halt,
  output logic            fetch_err
);

  fetch_state_t    state_reg;
  logic [XLEN-1:0] ir_reg;
  logic            ir_valid_reg;
  logic            in_wait;
  logic            fetch_done;
  logic            wdog_expired;

  assign in_wait    = is_mem_wait(state_reg);
  assign fetch_done = (state_reg == ST_FETCH) && mem_ack && !redirect;

  // Control strobes are forced low while reset is held.
  assign mem_rd    = reset && in_wait;
  assign mem_addr  = pc;
  assign pc_ld     = reset && redirect;
  assign pc_inc    = reset && fetch_done;
  assign pc_target = redirect_addr;

  assign ir       = ir_reg;
  assign ir_valid = ir_valid_reg;

`ifdef FETCH_SEQ_TIMEOUT_EN
  logic wdog_count_en;
  logic fetch_err_reg;

  assign wdog_count_en = reset && in_wait && !mem_ack && !redirect;

  fetch_wdog u_wdog (
    .clk      (clk),
    .reset    (reset),
    .count_en (wdog_count_en),
    .expired  (wdog_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_err_reg <= 1'b0;
    end else if (wdog_expired) begin
      fetch_err_reg <= 1'b1;
    end
  end

  assign fetch_err = fetch_err_reg;
`else
  assign wdog_expired = 1'b0;
  assign fetch_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= ST_FETCH;
      ir_reg       <= '0;
      ir_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_FETCH: begin
          // A redirect racing the ack drops the word and refetches at the new PC.
          if (redirect) begin
            state_reg <= mem_ack ? ST_FETCH : ST_FLUSH;
          end else if (mem_ack) begin
            ir_reg       <= mem_data;
            ir_valid_reg <= 1'b1;
            state_reg    <= ST_HOLD;
          end else if (wdog_expired) begin
            state_reg <= ST_HALT;
          end
        end
        ST_FLUSH: begin
          if (mem_ack) begin
            state_reg <= ST_FETCH;
          end else if (wdog_expired) begin
            state_reg <= ST_HALT;
          end
        end
        ST_HOLD: begin
          if (redirect) begin
            ir_valid_reg <= 1'b0;
            state_reg    <= ST_FETCH;
          end else if (ir_ready) begin
            ir_valid_reg <= 1'b0;
            state_reg    <= halt ? ST_HALT : ST_FETCH;
          end
        end
        ST_HALT: begin
          if (redirect) begin
            state_reg <= ST_FETCH;
          end
        end
        default: begin
          ir_valid_reg <= 1'b0;
          state_reg    <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed plus randomized bench for fetch_seq against a cycle-level
// behavioural model of the fetch rules.
module tb_fetch_seq;

`ifdef FETCH_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int TIMEOUT_CYCLES = 255;

  logic        clk;
  logic        reset;
  logic [15:0] pc;
  logic        pc_ld;
  logic        pc_inc;
  logic [15:0] pc_target;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic        halt;
  logic        fetch_err;

  fetch_seq dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .pc_ld         (pc_ld),
    .pc_inc        (pc_inc),
    .pc_target     (pc_target),
    .mem_rd        (mem_rd),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_data      (mem_data),
    .ir            (ir),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .halt          (halt),
    .fetch_err     (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: one of fetching / discarding / holding / halted, plus the
  // architectural PC the bench owns, the last accepted word and the error flag.
  bit          m_fetching, m_discarding, m_holding, m_halted;
  bit          m_known = 1'b0;
  bit          m_err;
  logic [15:0] m_ir;
  logic [15:0] m_pc;
  int          m_idle;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst_n, input bit ack, input logic [15:0] data,
                      input bit rdy, input bit redir, input logic [15:0] raddr,
                      input bit hlt);
    bit exp_rd;
    bit exp_ld;
    bit exp_inc;
    bit idle_wait;
    bit tmo;
    reset         = rst_n;
    mem_ack       = ack;
    mem_data      = data;
    ir_ready      = rdy;
    redirect      = redir;
    redirect_addr = raddr;
    halt          = hlt;
    pc            = m_pc;
    exp_rd  = rst_n && (m_fetching || m_discarding);
    exp_ld  = rst_n && redir;
    exp_inc = rst_n && m_fetching && ack && !redir;
    @(negedge clk);
    chk("mem_rd", mem_rd, exp_rd);
    chk("pc_ld", pc_ld, exp_ld);
    chk("pc_inc", pc_inc, exp_inc);
    if (exp_rd) chk("mem_addr", mem_addr, m_pc);
    if (exp_ld) chk("pc_target", pc_target, raddr);
    if (m_known) begin
      chk("ir_valid", ir_valid, m_holding);
      chk("ir", ir, m_ir);
      chk("fetch_err", fetch_err, m_err);
    end
    @(posedge clk);
    if (!rst_n) begin
      m_fetching = 1; m_discarding = 0; m_holding = 0; m_halted = 0;
      m_ir = 16'h0000; m_err = 0; m_idle = 0; m_known = 1;
    end else begin
      idle_wait = (m_fetching || m_discarding) && !ack && !redir;
      tmo       = TMO_EN && idle_wait && (m_idle == TIMEOUT_CYCLES);
      m_idle    = (idle_wait && !tmo) ? m_idle + 1 : 0;
      if (redir) m_pc = raddr;
      else if (m_fetching && ack) m_pc = m_pc + 16'd1;
      if (m_fetching) begin
        if (redir) begin
          m_fetching = ack; m_discarding = !ack;
        end else if (ack) begin
          m_ir = data; m_fetching = 0; m_holding = 1;
        end else if (tmo) begin
          m_fetching = 0; m_halted = 1; m_err = 1;
        end
      end else if (m_discarding) begin
        if (ack) begin
          m_discarding = 0; m_fetching = 1;
        end else if (tmo) begin
          m_discarding = 0; m_halted = 1; m_err = 1;
        end
      end else if (m_holding) begin
        if (redir) begin
          m_holding = 0; m_fetching = 1;
        end else if (rdy) begin
          m_holding = 0;
          if (hlt) m_halted = 1; else m_fetching = 1;
        end
      end else if (m_halted) begin
        if (redir) begin
          m_halted = 0; m_fetching = 1;
        end
      end
    end
    #1;
    $display("step rst=%0b ack=%0b rdy=%0b redir=%0b halt=%0b pc=%h ir=%h ir_valid=%0b err=%0b",
             rst_n, ack, rdy, redir, hlt, pc, ir, ir_valid, fetch_err);
  endtask

  initial begin
    int pulses;
    bit r_ack, r_rdy, r_redir, r_halt, r_rst;
    reset = 1'b0; mem_ack = 1'b0; mem_data = '0; ir_ready = 1'b0;
    redirect = 1'b0; redirect_addr = '0; halt = 1'b0;
    m_pc = 16'($urandom);
    pc   = m_pc;

    // Reset with redirect and acks active: strobes must stay low.
    repeat (3) step(0, 1'($urandom_range(0, 1)), 16'($urandom), 1, 1, 16'h1234, 0);

    // First fetch at pc 0, ack after two cycles.
    m_pc = 16'h0000;
    step(1, 0, 16'h0000, 0, 0, 16'h0000, 0);
    step(1, 0, 16'h0000, 0, 0, 16'h0000, 0);
    step(1, 1, 16'hA5A5, 0, 0, 16'h0000, 0);
    chk("first_ir", ir, 16'hA5A5);
    chk("first_valid", ir_valid, 1'b1);
    chk("first_pc", m_pc, 16'h0001);

    // Decode stall for five cycles with stray acks, then accept.
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, 1'(i % 2), 16'($urandom), 0, 0, 16'h0000, 0);
      pulses += int'(pc_inc);
    end
    chk("stall_ir", ir, 16'hA5A5);
    chk("stall_inc", 16'(pulses), 16'd0);
    step(1, 0, 16'h0000, 1, 0, 16'h0000, 0);
    chk("resume_rd", mem_rd, 1'b1);

    // Redirect while the read is pending; flush discards the next ack.
    step(1, 0, 16'h0000, 0, 1, 16'h0040, 0);
    step(1, 0, 16'h0000, 0, 0, 16'h0000, 0);
    step(1, 1, 16'hDEAD, 0, 0, 16'h0000, 0);
    chk("flush_valid", ir_valid, 1'b0);
    step(1, 0, 16'h0000, 0, 0, 16'h0000, 0);
    step(1, 1, 16'h1234, 0, 0, 16'h0000, 0);
    chk("redir_ir", ir, 16'h1234);
    step(1, 0, 16'h0000, 1, 0, 16'h0000, 0);

    // Redirect coinciding with the ack.
    step(1, 1, 16'hBEEF, 0, 1, 16'h0200, 0);
    chk("race_valid", ir_valid, 1'b0);
    step(1, 1, 16'h5555, 0, 0, 16'h0000, 0);

    // Redirect in hold drops the word even with ir_ready.
    step(1, 0, 16'h0000, 1, 1, 16'h0300, 0);
    chk("drop_valid", ir_valid, 1'b0);
    step(1, 1, 16'h7777, 0, 0, 16'h0000, 0);

    // Halt on accept, stray acks ignored, redirect resumes at 0x0100.
    step(1, 0, 16'h0000, 1, 0, 16'h0000, 1);
    repeat (3) step(1, 1'($urandom_range(0, 1)), 16'($urandom), 1, 0, 16'h0000, 1);
    chk("halt_rd", mem_rd, 1'b0);
    step(1, 0, 16'h0000, 0, 1, 16'h0100, 0);
    chk("halt_pc", m_pc, 16'h0100);
    step(1, 1, 16'h0101, 0, 0, 16'h0000, 0);
    step(1, 0, 16'h0000, 1, 0, 16'h0000, 0);

    // Reset mid-fetch; the next request uses the pc present afterwards.
    step(1, 0, 16'h0000, 0, 0, 16'h0000, 0);
    m_pc = 16'($urandom);
    step(0, 0, 16'h0000, 0, 0, 16'h0000, 0);
    step(1, 0, 16'h0000, 0, 0, 16'h0000, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r_ack   = ($urandom_range(0, 2) == 0);
      r_rdy   = ($urandom_range(0, 1) == 0);
      r_redir = ($urandom_range(0, 7) == 0);
      r_halt  = ($urandom_range(0, 5) == 0);
      r_rst   = ($urandom_range(0, 63) != 0);
      step(r_rst, r_ack, 16'($urandom), r_rdy, r_redir, 16'($urandom), r_halt);
    end

    // Long ack drought from a clean fetch.
    step(0, 0, 16'h0000, 0, 0, 16'h0000, 0);
    repeat (270) step(1, 0, 16'h0000, 0, 0, 16'h0000, 0);
    chk("drought_err", fetch_err, TMO_EN);
    chk("drought_rd", mem_rd, !TMO_EN);
    step(1, 0, 16'h0000, 0, 1, 16'h0010, 0);
    step(1, 1, 16'h0F0F, 0, 0, 16'h0000, 0);
    chk("drought_sticky", fetch_err, TMO_EN);
    step(0, 0, 16'h0000, 0, 0, 16'h0000, 0);
    chk("final_err", fetch_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
